clkdiv_driver: RTL and testbench

Programmable, glitch-free synchronous clock divider that generates the low-frequency clock/strobe fed into the `buffer_36x` two-inverter 36x driver for distribution to heavily loaded nets. Output `O` is driven directly from a flop, so the downstream buffer never sees combinational glitches. The divide ratio can be changed at run time through a load/acknowledge handshake. The change takes effect only at a period boundary. Start and stop requests are also honoured only at period boundaries.

---
 rtl/clkdiv_driver_pkg.sv | 12 +
 rtl/clkdiv_cnt.sv | 34 +++
 rtl/clkdiv_driver.sv | 123 ++++++++++++
 tb/tb_clkdiv_driver.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/clkdiv_driver_pkg.sv
// Shared definitions for the clkdiv_driver slice: FSM states and ratio limits.
package clkdiv_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } state_e;

  localparam int unsigned CLKDIV_MIN_RATIO = 2;

endpackage

// File: rtl/clkdiv_cnt.sv
// Loadable down-counter; holds at zero until reloaded.
module clkdiv_cnt #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/clkdiv_driver.sv
// Glitch-free programmable clock divider; ratio changes, start and stop are
// applied only at period boundaries. O comes straight from a flop.
module clkdiv_driver
  import clkdiv_driver_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             DIV_LD,
  output logic             DIV_ACK,
  output logic             TICK,
  output logic             O
);

  localparam logic [WIDTH-1:0] MIN_R = WIDTH'(CLKDIV_MIN_RATIO);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ratio_q, ratio_d;
  logic [WIDTH-1:0] pend_val_q, pend_val_d;
  logic             pend_vld_q, pend_vld_d;
  logic             o_q, o_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;

  logic             boundary;
  logic [WIDTH-1:0] next_r;
  logic [WIDTH-1:0] div_safe;
  logic             cnt_ld;
  logic [WIDTH-1:0] cnt_ld_val;
  logic             cnt_zero;

  assign div_safe = (DIV < MIN_R) ? MIN_R : DIV;

  clkdiv_cnt #(.WIDTH(WIDTH)) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .load     (cnt_ld),
    .load_val (cnt_ld_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    ratio_d    = ratio_q;
    pend_val_d = pend_val_q;
    pend_vld_d = pend_vld_q;
    o_d        = o_q;
    tick_d     = 1'b0;
    ack_d      = 1'b0;
    cnt_ld     = 1'b0;
    cnt_ld_val = '0;
    boundary   = 1'b0;
    next_r     = ratio_q;

    case (state_q)
      ST_IDLE: begin
        o_d = 1'b0;
        if (EN) boundary = 1'b1;
      end
      ST_HI: begin
        if (cnt_zero) begin
          state_d    = ST_LO;
          cnt_ld     = 1'b1;
          cnt_ld_val = ratio_q - (ratio_q >> 1) - WIDTH'(1);
          o_d        = 1'b0;
        end
      end
      ST_LO: begin
        if (cnt_zero) begin
          if (EN) boundary = 1'b1;
          else    state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (boundary) begin
      next_r     = pend_vld_q ? pend_val_q : ratio_q;
      ratio_d    = next_r;
      pend_vld_d = 1'b0;
      ack_d      = pend_vld_q;
      tick_d     = 1'b1;
      o_d        = 1'b1;
      state_d    = ST_HI;
      cnt_ld     = 1'b1;
      cnt_ld_val = (next_r >> 1) - WIDTH'(1);
    end

    // Applied after the boundary so a same-edge load waits for the next one.
    if (DIV_LD) begin
      pend_val_d = div_safe;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      ratio_q    <= MIN_R;
      pend_val_q <= MIN_R;
      pend_vld_q <= 1'b0;
      o_q        <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ratio_q    <= ratio_d;
      pend_val_q <= pend_val_d;
      pend_vld_q <= pend_vld_d;
      o_q        <= o_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
    end
  end

  assign O       = o_q;
  assign TICK    = tick_q;
  assign DIV_ACK = ack_q;

endmodule

// File: tb/tb_clkdiv_driver.sv
// Bench for clkdiv_driver: directed test-plan scenarios plus random traffic,
// checked each cycle against a period-position reference model.
module tb_clkdiv_driver;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic [3:0] DIV = 4'd0;
  logic       DIV_LD = 1'b0;
  logic       DIV_ACK;
  logic       TICK;
  logic       O;

  int vectors = 0;
  int errors  = 0;

  // Reference model: position within the current period, active ratio, pending.
  bit m_run, m_pend, m_tick, m_ack;
  int m_r, m_pos, m_pend_val;

  clkdiv_driver #(.WIDTH(4)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .DIV     (DIV),
    .DIV_LD  (DIV_LD),
    .DIV_ACK (DIV_ACK),
    .TICK    (TICK),
    .O       (O)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge();
    bit bnd;
    bnd = 1'b0;
    if (RST) begin
      m_run = 0; m_r = 2; m_pend = 0; m_tick = 0; m_ack = 0; m_pos = 0;
    end else begin
      m_tick = 0;
      m_ack  = 0;
      if (!m_run) bnd = EN;
      else if (m_pos == m_r - 1) begin
        if (EN) bnd = 1'b1;
        else    m_run = 0;
      end else m_pos++;
      if (bnd) begin
        m_ack = m_pend;
        if (m_pend) m_r = m_pend_val;
        m_pend = 0;
        m_run  = 1;
        m_pos  = 0;
        m_tick = 1;
      end
      if (DIV_LD) begin
        m_pend_val = (int'(DIV) < 2) ? 2 : int'(DIV);
        m_pend     = 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    chk("O", int'(O), int'(m_run && (m_pos < m_r / 2)));
    chk("TICK", int'(TICK), int'(m_tick));
    chk("DIV_ACK", int'(DIV_ACK), int'(m_ack));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load(input int v);
    DIV = 4'(v);
    DIV_LD = 1'b1;
    cycle();
    DIV_LD = 1'b0;
  endtask

  // Advance until the model reports a period start; expiry is a miscompare.
  task automatic wait_tick(input int budget);
    int k;
    k = 0;
    while (!m_tick && k < budget) begin
      cycle();
      k++;
    end
    chk("wait_tick", int'(m_tick), 1);
  endtask

  initial begin
    m_run = 0; m_r = 2; m_pend = 0; m_tick = 0; m_ack = 0; m_pos = 0; m_pend_val = 2;
    @(negedge CLK);

    // Reset held with EN high, then release into the default 1/1 pattern.
    RST = 1'b1; EN = 1'b1;
    run(3);
    RST = 1'b0;
    run(8);

    // Odd ratio.
    load(5);
    run(15);

    // Mid-period change: R=8 running, load 3 on HI cycle 2.
    load(8);
    wait_tick(20);
    run(8);
    wait_tick(20);
    cycle();
    load(3);
    run(14);

    // Overwrite with an invalid ratio before the boundary.
    load(6);
    load(1);
    run(10);

    // Stop mid-HI at R=6, then restart.
    load(6);
    wait_tick(20);
    wait_tick(20);
    EN = 1'b0;
    run(10);
    EN = 1'b1;
    run(8);

    // Reset during LO at R=10 with a value pending.
    load(10);
    wait_tick(20);
    wait_tick(20);
    run(6);
    load(4);
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    run(10);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) EN = ~EN;
      DIV_LD = ($urandom_range(0, 14) == 0);
      DIV = 4'($urandom_range(0, 15));
      cycle();
    end
    RST = 1'b0; DIV_LD = 1'b0;
    run(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
